// File: rtl/control_fsm_param.sv
// Control sequencer for the accumulator datapath: fetch/decode/execute with memory wait states,
// configurable GP register file size, illegal-opcode trap and a retired-instruction counter.
module control_fsm_param #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned OPW      = 5,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned RIW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int unsigned WEW     = 6 + NUM_REGS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [OPW+RIW-1:0]   instruction,
    input  logic                 z,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic [3:0]           read_en,
    output logic [WEW-1:0]       write_en,
    output logic [2:0]           inc_en,
    output logic [2:0]           clr_en,
    output logic [2:0]           alu_op,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_W-1:0]     instr_count
);

    localparam logic [4:0] StIdle   = 5'd0;
    localparam logic [4:0] StStart  = 5'd1;
    localparam logic [4:0] StFetch1 = 5'd2;
    localparam logic [4:0] StFetch2 = 5'd3;
    localparam logic [4:0] StLd1    = 5'd4;
    localparam logic [4:0] StLdi1   = 5'd5;
    localparam logic [4:0] StLd2    = 5'd6;
    localparam logic [4:0] StSt1    = 5'd7;
    localparam logic [4:0] StMvacar = 5'd8;
    localparam logic [4:0] StMvacr  = 5'd9;
    localparam logic [4:0] StMvrac  = 5'd10;
    localparam logic [4:0] StAdd    = 5'd11;
    localparam logic [4:0] StSub    = 5'd12;
    localparam logic [4:0] StMult   = 5'd13;
    localparam logic [4:0] StLsh    = 5'd14;
    localparam logic [4:0] StInac   = 5'd15;
    localparam logic [4:0] StClac   = 5'd16;
    localparam logic [4:0] StJcnz   = 5'd17;
    localparam logic [4:0] StJcz    = 5'd18;
    localparam logic [4:0] StJump   = 5'd19;
    localparam logic [4:0] StHalt   = 5'd20;

    localparam logic [3:0] RdIr = 4'd3;
    localparam logic [3:0] RdAc = 4'd4;
    localparam logic [3:0] RdDm = 4'd5;
    localparam logic [3:0] RdIm = 4'd6;

    logic [4:0]       state_q, state_d;
    logic             error_q;
    logic [CNT_W-1:0] cnt_q;
    logic [OPW-1:0]   opcode;
    logic [RIW-1:0]   reg_idx;
    logic             idx_ok;
    logic             illegal;
    logic [4:0]       dispatch;
    logic [WEW-1:0]   reg_we;

    assign opcode  = instruction[OPW+RIW-1:RIW];
    assign reg_idx = instruction[RIW-1:0];
    assign idx_ok  = 32'(reg_idx) < NUM_REGS;

    always_comb begin
        illegal  = 1'b0;
        dispatch = StHalt;
        case (opcode)
            OPW'(0):  dispatch = StFetch1;
            OPW'(1):  dispatch = StLd1;
            OPW'(2):  dispatch = StLdi1;
            OPW'(3):  dispatch = StSt1;
            OPW'(4):  dispatch = StMvacar;
            OPW'(5):  if (idx_ok) dispatch = StMvacr; else illegal = 1'b1;
            OPW'(6):  if (idx_ok) dispatch = StMvrac; else illegal = 1'b1;
            OPW'(7):  dispatch = StAdd;
            OPW'(8):  dispatch = StSub;
            OPW'(9):  dispatch = StMult;
            OPW'(10): dispatch = StLsh;
            OPW'(11): dispatch = StInac;
            OPW'(12): dispatch = StClac;
            OPW'(13): dispatch = StJcnz;
            OPW'(14): dispatch = StJcz;
            OPW'(15): dispatch = StJump;
            OPW'(31): dispatch = StHalt;
            default:  illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start) state_d = StStart;
            StStart:  state_d = StFetch1;
            StFetch1: if (mem_ready) state_d = StFetch2;
            StFetch2: state_d = dispatch;
            StLd1:    state_d = StLd2;
            StLdi1:   state_d = StLd2;
            StLd2:    if (mem_ready) state_d = StFetch1;
            StSt1:    if (mem_ready) state_d = StFetch1;
            StJcnz:   state_d = z ? StFetch1 : StJump;
            StJcz:    state_d = z ? StJump : StFetch1;
            StHalt:   if (start) state_d = StStart;
            StMvacar, StMvacr, StMvrac, StAdd, StSub, StMult, StLsh,
            StInac, StClac, StJump: state_d = StFetch1;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StFetch2) begin
                if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
                if (illegal) error_q <= 1'b1;
            end
            if (state_q == StHalt && start) begin
                error_q <= 1'b0;
                cnt_q   <= '0;
            end
        end
    end

    always_comb begin
        reg_we = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(reg_idx) == i) reg_we[6+i] = 1'b1;
        end
    end

    // Memory-sourced writes only fire in the cycle the access completes.
    always_comb begin
        mem_req  = 1'b0;
        read_en  = 4'd0;
        write_en = '0;
        inc_en   = 3'b000;
        clr_en   = 3'b000;
        alu_op   = 3'd0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            StIdle:   busy = 1'b0;
            StStart:  clr_en = 3'b011;
            StFetch1: begin
                mem_req     = 1'b1;
                read_en     = RdIm;
                write_en[2] = mem_ready;
            end
            StFetch2: inc_en = 3'b001;
            StLd1:    begin read_en = RdAc; write_en[1] = 1'b1; end
            StLdi1:   begin read_en = RdIr; write_en[1] = 1'b1; end
            StLd2:    begin
                mem_req     = 1'b1;
                read_en     = RdDm;
                write_en[3] = mem_ready;
            end
            StSt1:    begin
                mem_req     = 1'b1;
                read_en     = RdAc;
                write_en[4] = mem_ready;
            end
            StMvacar: begin read_en = RdAc; write_en[1] = 1'b1; end
            StMvacr:  begin read_en = RdAc; write_en = reg_we; end
            StMvrac:  begin read_en = 4'd8 + 4'(reg_idx); write_en[3] = 1'b1; end
            StAdd:    begin write_en[3] = 1'b1; write_en[5] = 1'b1; alu_op = 3'd1; end
            StSub:    begin write_en[3] = 1'b1; write_en[5] = 1'b1; alu_op = 3'd2; end
            StMult:   begin write_en[3] = 1'b1; write_en[5] = 1'b1; alu_op = 3'd3; end
            StLsh:    begin write_en[3] = 1'b1; write_en[5] = 1'b1; alu_op = 3'd4; end
            StInac:   inc_en = 3'b100;
            StClac:   clr_en = 3'b100;
            StJump:   begin read_en = RdIr; write_en[0] = 1'b1; end
            StHalt:   begin busy = 1'b0; done = 1'b1; end
            default:  busy = 1'b1;
        endcase
    end

    assign error       = error_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_control_fsm_param.sv
// Bench for control_fsm_param: per-instruction micro-op sequences derived from the ISA rules,
// driven with randomized wait states, flags and spurious start pulses.
module tb_control_fsm_param;

    localparam int NR  = 4;
    localparam int WEW = 10;
    localparam int VW  = 1 + 4 + WEW + 3 + 3 + 3 + 1 + 1 + 1 + 16;

    logic           clk = 1'b0;
    logic           rst_n, start, z, mem_ready;
    logic [6:0]     instruction;
    logic           mem_req;
    logic [3:0]     read_en;
    logic [WEW-1:0] write_en;
    logic [2:0]     inc_en, clr_en, alu_op;
    logic           busy, done, error;
    logic [15:0]    instr_count;

    control_fsm_param dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .instruction (instruction),
        .z           (z),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .read_en     (read_en),
        .write_en    (write_en),
        .inc_en      (inc_en),
        .clr_en      (clr_en),
        .alu_op      (alu_op),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        rst_val = 1'b0;
    logic [6:0]  instr = '0;
    logic        exp_err = 1'b0;
    logic [15:0] exp_cnt = '0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [WEW-1:0] web(input int b);
        return WEW'(1) << b;
    endfunction

    function automatic logic [VW-1:0] bvec(input logic mreq, input logic [3:0] rd,
                                           input logic [WEW-1:0] we, input logic [2:0] inc,
                                           input logic [2:0] clr, input logic [2:0] alu);
        return {mreq, rd, we, inc, clr, alu, 1'b1, 1'b0, exp_err, exp_cnt};
    endfunction

    function automatic logic [VW-1:0] halt_vec();
        return {1'b0, 4'd0, {WEW{1'b0}}, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, exp_err, exp_cnt};
    endfunction

    function automatic logic legal(input logic [4:0] op, input logic [1:0] idx);
        if (op == 5'd5 || op == 5'd6) return int'(idx) < NR;
        return (op <= 5'd15) || (op == 5'd31);
    endfunction

    task automatic cyc(input logic [VW-1:0] e, input logic mr, input logic zz, input logic st,
                       input string tag);
        logic [VW-1:0] obs;
        @(negedge clk);
        rst_n       = rst_val;
        mem_ready   = mr;
        z           = zz;
        start       = st;
        instruction = instr;
        #1;
        obs = {mem_req, read_en, write_en, inc_en, clr_en, alu_op, busy, done, error,
               instr_count};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    task automatic begin_run(input logic from_halt);
        if (from_halt) begin
            cyc(halt_vec(), rb(), rb(), 1'b1, "halt_start");
            exp_err = 1'b0;
            exp_cnt = '0;
        end else begin
            cyc('0, rb(), rb(), 1'b1, "idle_start");
        end
        cyc(bvec(1'b0, 4'd0, '0, 3'd0, 3'b011, 3'd0), rb(), rb(), rb(), "start_clr");
    endtask

    task automatic mem_phase(input logic [3:0] rd, input int wbit, input int waits,
                             input string tag);
        repeat (waits) cyc(bvec(1'b1, rd, '0, 3'd0, 3'd0, 3'd0), 1'b0, rb(), rb(), tag);
        cyc(bvec(1'b1, rd, web(wbit), 3'd0, 3'd0, 3'd0), 1'b1, rb(), rb(), tag);
    endtask

    task automatic fetch(input logic [4:0] op, input logic [1:0] idx, input int waits);
        mem_phase(4'd6, 2, waits, "fetch1");
        instr = {op, idx};
        cyc(bvec(1'b0, 4'd0, '0, 3'b001, 3'd0, 3'd0), rb(), rb(), rb(), "fetch2");
        if (exp_cnt != 16'hFFFF) exp_cnt++;
    endtask

    task automatic exec(input logic [4:0] op, input logic [1:0] idx, input int waits,
                        input logic zv);
        logic br;
        fetch(op, idx, waits);
        if (!legal(op, idx)) begin
            exp_err = 1'b1;
            cyc(halt_vec(), rb(), rb(), 1'b0, "halt_illegal");
        end else begin
            case (op)
                5'd1: begin
                    cyc(bvec(1'b0, 4'd4, web(1), 3'd0, 3'd0, 3'd0), rb(), rb(), rb(), "ld1");
                    mem_phase(4'd5, 3, waits, "ld2");
                end
                5'd2: begin
                    cyc(bvec(1'b0, 4'd3, web(1), 3'd0, 3'd0, 3'd0), rb(), rb(), rb(), "ldi1");
                    mem_phase(4'd5, 3, waits, "ld2");
                end
                5'd3: mem_phase(4'd4, 4, waits, "st1");
                5'd4: cyc(bvec(1'b0, 4'd4, web(1), 3'd0, 3'd0, 3'd0), rb(), rb(), rb(),
                          "mvacar");
                5'd5: cyc(bvec(1'b0, 4'd4, web(6 + int'(idx)), 3'd0, 3'd0, 3'd0), rb(), rb(),
                          rb(), "mvacr");
                5'd6: cyc(bvec(1'b0, 4'd8 + {2'b00, idx}, web(3), 3'd0, 3'd0, 3'd0), rb(),
                          rb(), rb(), "mvrac");
                5'd7, 5'd8, 5'd9, 5'd10:
                    cyc(bvec(1'b0, 4'd0, web(3) | web(5), 3'd0, 3'd0, 3'(op - 5'd6)), rb(),
                        rb(), rb(), "alu");
                5'd11: cyc(bvec(1'b0, 4'd0, '0, 3'b100, 3'd0, 3'd0), rb(), rb(), rb(), "inac");
                5'd12: cyc(bvec(1'b0, 4'd0, '0, 3'd0, 3'b100, 3'd0), rb(), rb(), rb(), "clac");
                5'd13, 5'd14: begin
                    cyc(bvec(1'b0, 4'd0, '0, 3'd0, 3'd0, 3'd0), rb(), zv, rb(), "jcond");
                    br = (op == 5'd13) ? !zv : zv;
                    if (br) cyc(bvec(1'b0, 4'd3, web(0), 3'd0, 3'd0, 3'd0), rb(), rb(), rb(),
                                "jump");
                end
                5'd15: cyc(bvec(1'b0, 4'd3, web(0), 3'd0, 3'd0, 3'd0), rb(), rb(), rb(),
                           "jump");
                5'd31: cyc(halt_vec(), rb(), rb(), 1'b0, "halt_end");
                default: ;
            endcase
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; z = 1'b0; mem_ready = 1'b0; instruction = '0;
        repeat (2) @(posedge clk);
        cyc('0, 1'b1, 1'b1, 1'b1, "reset_idle");
        rst_val = 1'b1;
        cyc('0, rb(), rb(), 1'b0, "idle_hold");

        // NOP, END with no wait states
        begin_run(1'b0);
        exec(5'd0, 2'd0, 0, 1'b0);
        exec(5'd31, 2'd0, 0, 1'b0);
        cyc(halt_vec(), rb(), rb(), 1'b0, "halt_hold");

        // Fetch wait states, register moves, branches
        begin_run(1'b1);
        exec(5'd0, 2'd0, 3, 1'b0);
        exec(5'd5, 2'd3, 0, 1'b0);
        exec(5'd6, 2'd2, 1, 1'b0);
        exec(5'd13, 2'd0, 0, 1'b0);
        exec(5'd13, 2'd0, 0, 1'b1);
        exec(5'd14, 2'd0, 0, 1'b1);
        exec(5'd14, 2'd0, 0, 1'b0);
        exec(5'd15, 2'd0, 0, 1'b0);
        exec(5'd31, 2'd0, 0, 1'b0);

        // Illegal opcode trap, then restart clears error/count
        begin_run(1'b1);
        exec(5'd11, 2'd0, 0, 1'b0);
        exec(5'd20, 2'd1, 0, 1'b0);
        cyc(halt_vec(), rb(), rb(), 1'b0, "halt_err_hold");
        begin_run(1'b1);

        // Reset in the middle of an LD2 wait
        fetch(5'd1, 2'd0, 0);
        cyc(bvec(1'b0, 4'd4, web(1), 3'd0, 3'd0, 3'd0), rb(), rb(), rb(), "ld1");
        cyc(bvec(1'b1, 4'd5, '0, 3'd0, 3'd0, 3'd0), 1'b0, rb(), rb(), "ld2_wait");
        rst_val = 1'b0;
        cyc(bvec(1'b1, 4'd5, '0, 3'd0, 3'd0, 3'd0), 1'b0, rb(), rb(), "ld2_rst_edge");
        exp_err = 1'b0;
        exp_cnt = '0;
        cyc('0, 1'b1, rb(), rb(), "rst_idle");
        rst_val = 1'b1;
        cyc('0, rb(), rb(), 1'b0, "idle_after_rst");
        begin_run(1'b0);
        exec(5'd0, 2'd1, 2, 1'b0);
        exec(5'd31, 2'd0, 0, 1'b0);

        // Random programs
        for (int p = 0; p < 30; p++) begin
            int n;
            begin_run(1'b1);
            n = int'($urandom_range(1, 12));
            for (int i = 0; i < n; i++) begin
                exec(5'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), rb());
            end
            if (rb()) exec(5'd31, 2'd0, int'($urandom_range(0, 2)), 1'b0);
            else exec(5'($urandom_range(16, 30)), 2'($urandom_range(0, 3)), 0, 1'b0);
            cyc(halt_vec(), rb(), rb(), 1'b0, "halt_hold_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
